// File: rtl/adder_input_ctrl.sv
// Pushbutton front end for an external 16-bit adder: debounced LoadA/LoadB/Run
// buttons latch operands from SW, then Run captures the adder result after ADD_LAT clocks.
`timescale 1ns/1ps

module adder_input_ctrl_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
            else                              cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

module adder_input_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int ADD_LAT    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LoadA,
    input  logic        LoadB,
    input  logic        Run,
    input  logic [15:0] SW,
    input  logic [15:0] Sum_in,
    input  logic        CO_in,
    output logic [15:0] A_out,
    output logic [15:0] B_out,
    output logic [16:0] Result,
    output logic        Busy,
    output logic        Done
);
    localparam int NUM_BTN = 3;
    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_RUN = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [NUM_BTN-1:0] btn_n, lvl, press;
    logic [NUM_BTN-1:0] lvl_prev_q, lvl_prev_d;
    logic [1:0]         state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic [16:0]        result_q, result_d;
    logic               done_q, done_d;

    assign btn_n = {Run, LoadB, LoadA};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        adder_input_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (Clk),
            .rst_n (Reset),
            .btn_n (btn_n[i]),
            .level (lvl[i])
        );
    end

    // Press = first cycle the debounced level reads 0.
    assign press = lvl_prev_q & ~lvl;

    always_comb begin
        lvl_prev_d = lvl;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press[BTN_A]) a_d = SW;
                if (press[BTN_B]) b_d = SW;
                if (press[BTN_RUN]) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'(ADD_LAT - 1)) begin
                    result_d = {CO_in, Sum_in};
                    done_d   = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (lvl[BTN_RUN]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lvl_prev_q <= '1;
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            lvl_prev_q <= lvl_prev_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign A_out  = a_q;
    assign B_out  = b_q;
    assign Result = result_q;
    assign Done   = done_q;
    assign Busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_adder_input_ctrl.sv
// Bench for adder_input_ctrl: per-cycle check against a behavioural model plus
// hand-computed checks of operand loads, carry, debounce latency, HOLD and reset abort.
`timescale 1ns/1ps

module tb_adder_input_ctrl;
    localparam int DEB = 4;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        LoadA = 1'b1, LoadB = 1'b1, Run = 1'b1;
    logic [15:0] SW = '0;
    logic [15:0] Sum_in;
    logic        CO_in;
    logic [15:0] A_out, B_out;
    logic [16:0] Result;
    logic        Busy, Done;

    adder_input_ctrl #(.DEB_CYCLES(DEB), .ADD_LAT(LAT)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .LoadA  (LoadA),
        .LoadB  (LoadB),
        .Run    (Run),
        .SW     (SW),
        .Sum_in (Sum_in),
        .CO_in  (CO_in),
        .A_out  (A_out),
        .B_out  (B_out),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done)
    );

    // Downstream adder
    assign {CO_in, Sum_in} = {1'b0, A_out} + {1'b0, B_out};

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: button level flips when the last DEB synchronized samples
    // all disagree with it; FSM phases 0=idle 1=adding 2=waiting for Run release.
    bit          m_s1[3], m_s2[3], m_lvl[3], m_prev[3];
    logic [DEB-1:0] m_h[3];
    int          m_ph, m_left;
    logic [15:0] m_a, m_b;
    logic [16:0] m_res;
    bit          m_done;

    task automatic model_step();
        bit raw[3];
        bit pul[3];
        raw[0] = LoadA; raw[1] = LoadB; raw[2] = Run;
        if (!Reset) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 1; m_s2[b] = 1; m_lvl[b] = 1; m_prev[b] = 1; m_h[b] = '1;
            end
            m_ph = 0; m_left = 0; m_a = '0; m_b = '0; m_res = '0; m_done = 0;
        end else begin
            for (int b = 0; b < 3; b++) pul[b] = m_prev[b] && !m_lvl[b];
            m_done = 0;
            case (m_ph)
                0: begin
                    if (pul[0]) m_a = SW;
                    if (pul[1]) m_b = SW;
                    if (pul[2]) begin m_ph = 1; m_left = LAT; end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_res = {1'b0, m_a} + {1'b0, m_b};
                        m_done = 1;
                        m_ph = 2;
                    end
                end
                default: if (m_lvl[2]) m_ph = 0;
            endcase
            for (int b = 0; b < 3; b++) begin
                m_prev[b] = m_lvl[b];
                m_h[b] = (m_h[b] << 1) | DEB'(m_s2[b]);
                if (m_h[b] == {DEB{~m_lvl[b]}}) m_lvl[b] = ~m_lvl[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    initial forever begin
        @(negedge Clk);
        if (chk_on) begin
            chk("A_out", 32'(A_out), 32'(m_a));
            chk("B_out", 32'(B_out), 32'(m_b));
            chk("Result", 32'(Result), 32'(m_res));
            chk("Busy", 32'(Busy), 32'(m_ph != 0));
            chk("Done", 32'(Done), 32'(m_done));
            if (Done) done_cnt++;
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: LoadA = v;
            1: LoadB = v;
            default: Run = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b0);
        idle(len);
        set_btn(b, 1'b1);
    endtask

    int d0;

    initial begin
        idle(3);
        chk_on = 1'b1;
        chk("rst A_out", 32'(A_out), 32'h0);
        chk("rst B_out", 32'(B_out), 32'h0);
        chk("rst Result", 32'(Result), 32'h0);
        chk("rst Busy", 32'(Busy), 32'h0);
        chk("rst Done", 32'(Done), 32'h0);
        Reset = 1'b1;
        idle(2);

        // 1 + 2 with exact Run timing
        SW = 16'h0001; press(0, 6); idle(10);
        SW = 16'h0002; press(1, 6); idle(10);
        chk("load A", 32'(A_out), 32'h0001);
        chk("load B", 32'(B_out), 32'h0002);
        d0 = done_cnt;
        Run = 1'b0;
        idle(6);
        Run = 1'b1;
        chk("busy before run", 32'(Busy), 32'h0);
        idle(1);
        chk("busy run+1", 32'(Busy), 32'h1);
        idle(1);
        chk("done early", 32'(Done), 32'h0);
        idle(1);
        chk("done run+3", 32'(Done), 32'h1);
        idle(12);
        chk("sum 1+2", 32'(Result), 32'h00003);
        chk("one done", 32'(done_cnt - d0), 32'h1);
        chk("busy idle", 32'(Busy), 32'h0);

        // Carry out
        SW = 16'hFFFF; press(0, 6); idle(10);
        SW = 16'h0001; press(1, 6); idle(10);
        d0 = done_cnt;
        press(2, 6); idle(15);
        chk("carry", 32'(Result), 32'h10000);
        chk("carry one done", 32'(done_cnt - d0), 32'h1);

        // Short glitch ignored, then exact load latency
        SW = 16'h1234; press(0, 3); idle(15);
        chk("glitch", 32'(A_out), 32'hFFFF);
        LoadA = 1'b0; idle(4); LoadA = 1'b1;
        idle(2);
        chk("lat p+6", 32'(A_out), 32'hFFFF);
        idle(1);
        chk("lat p+7", 32'(A_out), 32'h1234);
        idle(10);

        // Release bounce gives no second pulse
        SW = 16'h0F0F; press(0, 8);
        SW = 16'hAAAA; idle(2); press(0, 2); idle(15);
        chk("bounce", 32'(A_out), 32'h0F0F);

        // Long Run hold with Load attempt during HOLD
        d0 = done_cnt;
        Run = 1'b0; idle(20);
        SW = 16'hBEEF; press(0, 6); idle(24);
        chk("hold busy", 32'(Busy), 32'h1);
        Run = 1'b1; idle(12);
        chk("hold busy fall", 32'(Busy), 32'h0);
        chk("hold A", 32'(A_out), 32'h0F0F);
        chk("hold result", 32'(Result), 32'h00F10);
        chk("hold one done", 32'(done_cnt - d0), 32'h1);

        // Reset in second WAIT cycle, Run still held afterwards
        d0 = done_cnt;
        Run = 1'b0; idle(8);
        Reset = 1'b0; idle(1);
        chk("abort done", 32'(Done), 32'h0);
        chk("abort result", 32'(Result), 32'h0);
        chk("abort A", 32'(A_out), 32'h0);
        chk("abort B", 32'(B_out), 32'h0);
        chk("abort busy", 32'(Busy), 32'h0);
        chk("abort no done", 32'(done_cnt - d0), 32'h0);
        Reset = 1'b1;
        idle(6);
        chk("rerun wait", 32'(Busy), 32'h0);
        idle(1);
        chk("rerun busy", 32'(Busy), 32'h1);
        Run = 1'b1; idle(15);
        chk("rerun result", 32'(Result), 32'h0);

        // Simultaneous presses
        SW = 16'h0005;
        LoadA = 1'b0; LoadB = 1'b0; Run = 1'b0;
        idle(6);
        LoadA = 1'b1; LoadB = 1'b1; Run = 1'b1;
        idle(15);
        chk("simul A", 32'(A_out), 32'h0005);
        chk("simul B", 32'(B_out), 32'h0005);
        chk("simul result", 32'(Result), 32'h0000A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_input_ctrl.md
ADDER_INPUT_CTRL -- requirements
Module: adder_input_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4, consecutive stable clocks before a debounced button level changes (legal 1..2^20).
REQ-002 Parameter ADD_LAT, default 2, clocks between operand presentation and result capture (legal 1..15).
REQ-003 Clk  in  1  single system clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset; sampled on rising edge of Clk.
REQ-005 LoadA  in  1  active-low pushbutton, asynchronous to Clk, bouncy.
REQ-006 LoadB  in  1  active-low pushbutton, asynchronous to Clk, bouncy.
REQ-007 Run  in  1  active-low pushbutton, asynchronous to Clk, bouncy.
REQ-008 SW  in  16  operand switches, sampled on Load press pulse.
REQ-009 Sum_in  in  16  sum returned by downstream adder.
REQ-010 CO_in  in  1  carry-out returned by downstream adder.
REQ-011 A_out  out  16  registered operand A to adder.
REQ-012 B_out  out  16  registered operand B to adder.
REQ-013 Result  out  17  captured {CO_in, Sum_in}.
REQ-014 Busy  out  1  high while an addition is in flight or Run still held.
REQ-015 Done  out  1  one-cycle pulse, Result just updated.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose level flips only after the synchronized value differs from it for DEB_CYCLES consecutive clocks; any agreeing cycle clears the count.
REQ-017 A press pulse SHALL be high exactly one cycle, the first cycle the debounced level reads 0; button held low from cycle p yields pulse at cycle p+2+DEB_CYCLES.
REQ-018 Low glitches shorter than DEB_CYCLES clocks SHALL produce no pulse; release bounce SHALL produce no pulse.
REQ-019 FSM states: IDLE, WAIT, HOLD.
REQ-020 IDLE: LoadA pulse SHALL load A_out<=SW, LoadB pulse B_out<=SW, visible next cycle; simultaneous pulses load both from same SW.
REQ-021 IDLE + Run pulse at cycle t: go WAIT at t+1, Busy=1 from t+1; Load pulses in cycle t still apply.
REQ-022 WAIT SHALL last exactly ADD_LAT cycles (t+1..t+ADD_LAT); on its last edge Result<={CO_in,Sum_in}, Done=1 during cycle t+ADD_LAT+1, state HOLD.
REQ-023 HOLD: stay while debounced Run is 0; on first cycle it reads 1, go IDLE, Busy=0 next cycle.
REQ-024 In WAIT and HOLD, Load and Run pulses SHALL be ignored (no operand change, no re-run, not queued).
REQ-025 A_out/B_out SHALL be stable throughout WAIT; Result SHALL hold between captures.
REQ-026 Result is unsigned 17-bit; no saturation or sign handling.

Reset
REQ-027 Reset=0 at a rising edge SHALL, by the next cycle: state IDLE; A_out=B_out=0; Result=0; Busy=0; Done=0; synchronizers and debounced levels=1 (released); debounce counters=0.
REQ-028 Reset mid-WAIT or HOLD SHALL abort without capture or Done; a button still held after Reset release SHALL produce a press pulse after the full REQ-017 latency.

Verification
REQ-029 Reset 0->1, SW=0x0001 LoadA press, SW=0x0002 LoadB press, Run press, adder model Sum=A+B -> A_out=0x0001, B_out=0x0002, Done one cycle at t+3, Result=0x00003.
REQ-030 A=0xFFFF, B=0x0001, Run -> Result=0x10000, Done single pulse.
REQ-031 DEB_CYCLES=4, LoadA low 3 clocks then high, SW=0x1234 -> A_out unchanged; low 4+ clocks -> A_out=0x1234 at p+7.
REQ-032 Run held 50 cycles, LoadA pressed during HOLD with SW=0xBEEF -> one Done only, A_out unchanged, Busy falls after Run released.
REQ-033 Reset asserted in second WAIT cycle -> no Done, Result=0, A_out=B_out=0, Busy=0 next cycle.
REQ-034 LoadA, LoadB, Run pressed in same cycle with SW=0x0005 -> A_out=B_out=0x0005, Result=0x0000A.
